pipelined_sum_tree: RTL and testbench
=====================================

# pipelined_sum_tree

Parametrised, pipelined adder tree that reduces INPUT_NUM operands to one sum, with a valid/ready handshake, any operand count, signed or unsigned arithmetic, and a configurable number of register stages. It sits in the reader's baseband math path and feeds correlator and energy-detect stages that sum many equal-width samples per cycle. It supports backpressure so a stalled downstream consumer never loses or duplicates a sum.

## Interface
- INPUT_NUM, 8, number of operands; any value ≥ 2, not limited to powers of two
- INPUT_WIDTH, 8, bit width of each operand
- STAGE_NUM, 2, number of register stages, 1..LEVEL_NUM
- SIGNED, 0, 1 = two's-complement operands and sign extension; 0 = unsigned and zero extension
- LEVEL_NUM (derived), $clog2(INPUT_NUM), adder levels in the tree
- OUTPUT_WIDTH (derived), INPUT_WIDTH+LEVEL_NUM, width of the sum

- clk  in  1  system clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- in_dat  in  INPUT_NUM*INPUT_WIDTH  concatenated operands; operand i is in_dat[i*INPUT_WIDTH +: INPUT_WIDTH]
- in_val  in  1  in_dat is valid
- in_rdy  out  1  tree accepts a beat this cycle
- out_dat  out  OUTPUT_WIDTH  sum
- out_val  out  1  out_dat is valid
- out_rdy  in  1  downstream accepts out_dat

## Operation
- Operands are padded with zeros up to 2**LEVEL_NUM.
- Level l (1..LEVEL_NUM) adds adjacent pairs from level l-1.
  - Each operand is extended by 1 bit (sign-extended if SIGNED=1, else zero-extended), so results at level l are INPUT_WIDTH+l bits.
  - Overflow is impossible; nothing is truncated or saturated.
- Levels are grouped into STAGE_NUM stages.
  - base = LEVEL_NUM/STAGE_NUM.
  - The first LEVEL_NUM%STAGE_NUM stages take base+1 levels; the remaining stages take base.
- Each stage ends in a data register plus a valid bit v[s]. The last stage's register drives out_dat/out_val.
- Global advance: adv = out_rdy | ~out_val; in_rdy = adv.
  - adv=1: every stage register loads its predecessor. v[0] loads in_val.
  - adv=0: all stage registers and valid bits hold.
- A beat is accepted on in_val & in_rdy. A beat is delivered on out_val & out_rdy.
- Data registers are not reset. Only valid bits are reset.
- Bubbles (in_val=0) propagate as v=0. Data in bubble slots is don't-care.

## Timing
- Reset (rst_n=0 at a clk edge): all v[s] ← 0, so out_val=0 and in_rdy=1 in the following cycle. out_dat is undefined until the first out_val.
- Reset mid-operation discards all in-flight beats. A beat presented in the reset cycle is dropped.
- Latency: a beat accepted at edge n appears with out_val=1 after edge n+STAGE_NUM-1, i.e. STAGE_NUM cycles after acceptance, provided no stall occurs.
- Throughput: 1 beat/cycle while out_rdy=1.
- Stall: out_val=1 & out_rdy=0 forces in_rdy=0 combinationally in the same cycle. out_dat/out_val hold stable until out_rdy=1.
- in_rdy depends combinationally on out_rdy. This is the only combinational input-to-output path.
- Simultaneous out_val & out_rdy & in_val: the output retires and the new beat enters in the same edge.
- STAGE_NUM=1: the whole tree is combinational into one register; latency 1.

## Structure
- Shared package rfid_math_pkg:
  - function sum_levels(n) = $clog2(n), minimum 1
  - function stage_levels(levels, stages, s), the level split defined above
  - function stage_first_level(levels, stages, s)
- Sub-module sum_tree_level: combinational, parameters PAIR_NUM, IN_WIDTH, SIGNED; adds adjacent pairs with 1-bit extension. The top instantiates it LEVEL_NUM times inside a generate loop and places a register after each stage's last level.
- Elaboration-time checks: STAGE_NUM in 1..LEVEL_NUM; INPUT_NUM ≥ 2.

## Test plan
- Defaults, unsigned, out_rdy=1: in_dat all operands 8'hFF, single beat → out_dat=11'd2040 two cycles after acceptance, out_val high for exactly one cycle.
- SIGNED=1, INPUT_NUM=5, INPUT_WIDTH=4, STAGE_NUM=3: operands {-8,-8,-8,-8,-8} → out_dat=-40 (7-bit 7'h58), latency 3.
- Stream of 20 back-to-back beats, operands = beat index k on every lane → out_dat=8k in order, one per cycle, with no gaps.
- Hold out_rdy=0 for 5 cycles mid-stream → in_rdy=0 while out_val=1, out_dat stable, and no beat lost or duplicated after release.
- Assert rst_n=0 for one cycle with 2 beats in flight → out_val=0 and in_rdy=1 next cycle, and neither in-flight beat ever appears.
- Randomised sweep over INPUT_NUM 2..17, STAGE_NUM 1..LEVEL_NUM, SIGNED 0/1, random in_val/out_rdy → scoreboard matches a reference sum exactly.

Source files
------------

// File: rtl/pipelined_sum_tree_pkg.sv
// Shared elaboration-time helpers for the baseband math blocks:
// the adder-tree depth and the split of tree levels into register stages.
package rfid_math_pkg;

    function automatic int unsigned sum_levels(input int unsigned n);
        int unsigned l;
        l = 1;
        for (int unsigned i = 1; i < 32; i++)
            if ((64'd1 << i) < 64'(n)) l = i + 1;
        return l;
    endfunction

    // The first levels%stages stages absorb one extra level each.
    function automatic int unsigned stage_levels(input int unsigned levels,
                                                 input int unsigned stages,
                                                 input int unsigned s);
        return (s < (levels % stages)) ? (levels / stages) + 1 : (levels / stages);
    endfunction

    function automatic int unsigned stage_first_level(input int unsigned levels,
                                                      input int unsigned stages,
                                                      input int unsigned s);
        int unsigned first;
        first = 1;
        for (int unsigned i = 0; i < s; i++)
            first = first + stage_levels(levels, stages, i);
        return first;
    endfunction

    function automatic bit is_stage_end(input int unsigned levels,
                                        input int unsigned stages,
                                        input int unsigned l);
        bit hit;
        hit = 1'b0;
        for (int unsigned s = 0; s < stages; s++)
            if (stage_first_level(levels, stages, s) + stage_levels(levels, stages, s) - 1 == l)
                hit = 1'b1;
        return hit;
    endfunction

endpackage

// File: rtl/sum_tree_level.sv
// One combinational adder-tree level: adds adjacent operand pairs,
// widening each result by one bit so nothing can overflow.
module sum_tree_level #(
    parameter int unsigned PAIR_NUM = 1,
    parameter int unsigned IN_WIDTH = 8,
    parameter bit          SIGNED   = 1'b0
) (
    input  logic [2*PAIR_NUM*IN_WIDTH-1:0]   in_dat_i,
    output logic [PAIR_NUM*(IN_WIDTH+1)-1:0] sum_o
);

    for (genvar p = 0; p < PAIR_NUM; p++) begin : g_pair
        logic [IN_WIDTH-1:0] a;
        logic [IN_WIDTH-1:0] b;
        logic                ext_a;
        logic                ext_b;

        assign a     = in_dat_i[(2*p)*IN_WIDTH   +: IN_WIDTH];
        assign b     = in_dat_i[(2*p+1)*IN_WIDTH +: IN_WIDTH];
        assign ext_a = SIGNED ? a[IN_WIDTH-1] : 1'b0;
        assign ext_b = SIGNED ? b[IN_WIDTH-1] : 1'b0;

        assign sum_o[p*(IN_WIDTH+1) +: IN_WIDTH+1] = {ext_a, a} + {ext_b, b};
    end

endmodule

// File: rtl/pipelined_sum_tree.sv
// Pipelined adder tree reducing INPUT_NUM operands to one sum, with a
// valid/ready handshake and a single global advance for all stages.
module pipelined_sum_tree
    import rfid_math_pkg::*;
#(
    parameter int unsigned INPUT_NUM   = 8,
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned STAGE_NUM   = 2,
    parameter bit          SIGNED      = 1'b0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [INPUT_NUM*INPUT_WIDTH-1:0]              in_dat,
    input  logic                                          in_val,
    output logic                                          in_rdy,
    output logic [INPUT_WIDTH+sum_levels(INPUT_NUM)-1:0]  out_dat,
    output logic                                          out_val,
    input  logic                                          out_rdy
);

    localparam int unsigned LEVEL_NUM = sum_levels(INPUT_NUM);
    localparam int unsigned LEAF_NUM  = 1 << LEVEL_NUM;

    if (INPUT_NUM < 2 || STAGE_NUM < 1 || STAGE_NUM > LEVEL_NUM) begin : g_bad_cfg
        $error("pipelined_sum_tree: INPUT_NUM must be >= 2 and STAGE_NUM in 1..LEVEL_NUM");
    end

    logic                          adv;
    logic [STAGE_NUM-1:0]          v_q;
    logic [STAGE_NUM-1:0]          v_d;
    logic [LEAF_NUM*INPUT_WIDTH-1:0] leaf;

    assign adv     = out_rdy | ~v_q[STAGE_NUM-1];
    assign in_rdy  = adv;
    assign out_val = v_q[STAGE_NUM-1];

    // Zero operands fill the tree up to a power of two; they do not change the sum.
    assign leaf = (LEAF_NUM*INPUT_WIDTH)'(in_dat);

    always_comb begin
        v_d = v_q;
        if (adv) begin
            v_d[0] = in_val;
            for (int unsigned s = 1; s < STAGE_NUM; s++)
                v_d[s] = v_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) v_q <= '0;
        else        v_q <= v_d;
    end

    for (genvar l = 1; l <= LEVEL_NUM; l++) begin : g_lvl
        localparam int unsigned PAIRS = LEAF_NUM >> l;
        localparam int unsigned IW    = INPUT_WIDTH + l - 1;

        logic [2*PAIRS*IW-1:0]     lvl_in;
        logic [PAIRS*(IW+1)-1:0]   sum_d;
        logic [PAIRS*(IW+1)-1:0]   lvl_out;

        if (l == 1) begin : g_leaf
            assign lvl_in = leaf;
        end else begin : g_chain
            assign lvl_in = g_lvl[l-1].lvl_out;
        end

        sum_tree_level #(
            .PAIR_NUM (PAIRS),
            .IN_WIDTH (IW),
            .SIGNED   (SIGNED)
        ) u_level (
            .in_dat_i (lvl_in),
            .sum_o    (sum_d)
        );

        // Data registers carry no reset; only the valid bits define occupancy.
        if (is_stage_end(LEVEL_NUM, STAGE_NUM, l)) begin : g_reg
            logic [PAIRS*(IW+1)-1:0] sum_q;
            always_ff @(posedge clk) begin
                if (adv) sum_q <= sum_d;
            end
            assign lvl_out = sum_q;
        end else begin : g_comb
            assign lvl_out = sum_d;
        end
    end

    assign out_dat = g_lvl[LEVEL_NUM].lvl_out;

endmodule

// File: tb/tb_pipelined_sum_tree.sv
// Directed bench for pipelined_sum_tree: four configurations covering
// unsigned/signed, padding, single-stage and multi-stage latency, streaming and stalls.
module tb_pipelined_sum_tree;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // d0: defaults (8 x 8-bit, 2 stages, unsigned)
    logic [63:0] d0_dat;
    logic        d0_val, d0_rdy, d0_irdy, d0_oval;
    logic [10:0] d0_out;
    // d1: 5 x 4-bit signed, 3 stages
    logic [19:0] d1_dat;
    logic        d1_val, d1_irdy, d1_oval;
    logic [6:0]  d1_out;
    // d2: 3 x 8-bit unsigned, 1 stage
    logic [23:0] d2_dat;
    logic        d2_val, d2_irdy, d2_oval;
    logic [9:0]  d2_out;
    // d3: 2 x 8-bit signed, 1 stage
    logic [15:0] d3_dat;
    logic        d3_val, d3_irdy, d3_oval;
    logic [8:0]  d3_out;

    pipelined_sum_tree u_d0 (
        .clk(clk), .rst_n(rst_n), .in_dat(d0_dat), .in_val(d0_val), .in_rdy(d0_irdy),
        .out_dat(d0_out), .out_val(d0_oval), .out_rdy(d0_rdy));

    pipelined_sum_tree #(.INPUT_NUM(5), .INPUT_WIDTH(4), .STAGE_NUM(3), .SIGNED(1'b1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_dat(d1_dat), .in_val(d1_val), .in_rdy(d1_irdy),
        .out_dat(d1_out), .out_val(d1_oval), .out_rdy(1'b1));

    pipelined_sum_tree #(.INPUT_NUM(3), .INPUT_WIDTH(8), .STAGE_NUM(1), .SIGNED(1'b0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_dat(d2_dat), .in_val(d2_val), .in_rdy(d2_irdy),
        .out_dat(d2_out), .out_val(d2_oval), .out_rdy(1'b1));

    pipelined_sum_tree #(.INPUT_NUM(2), .INPUT_WIDTH(8), .STAGE_NUM(1), .SIGNED(1'b1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_dat(d3_dat), .in_val(d3_val), .in_rdy(d3_irdy),
        .out_dat(d3_out), .out_val(d3_oval), .out_rdy(1'b1));

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    longint      exp_q[$];

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n beats (operand k on every lane) into d0, stalling out_rdy
    // for cycles [stall_lo, stall_hi), and checks order, stability and count.
    task automatic run_stream(input int n, input int stall_lo, input int stall_hi,
                              input bit check_gaps);
        int     k, cyc, delivered, first_cyc, last_cyc;
        bit     acc, prev_stall;
        logic [7:0]  kb;
        logic [10:0] held;
        longint exp;
        k = 0; cyc = 0; delivered = 0; first_cyc = -1; last_cyc = -1;
        prev_stall = 1'b0; held = '0;
        exp_q.delete();
        while ((k < n || exp_q.size() > 0 || d0_oval) && cyc < 200) begin
            kb     = k[7:0];
            d0_val = (k < n);
            d0_dat = {8{kb}};
            d0_rdy = !(cyc >= stall_lo && cyc < stall_hi);
            @(negedge clk);
            if (prev_stall) begin
                check_eq("stall_oval_hold", longint'(d0_oval), 1);
                check_eq("stall_dat_hold", longint'(d0_out), longint'(held));
            end
            if (d0_oval && !d0_rdy)
                check_eq("stall_in_rdy", longint'(d0_irdy), 0);
            acc = d0_val && d0_irdy;
            if (acc) exp_q.push_back(8 * k);
            if (d0_oval && d0_rdy) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check_eq("stream_dat", longint'(d0_out), exp);
                delivered++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            prev_stall = d0_oval && !d0_rdy;
            held       = d0_out;
            tick();
            if (acc) k++;
            cyc++;
        end
        d0_val = 1'b0;
        d0_rdy = 1'b1;
        check_eq("stream_timeout", longint'(cyc < 200), 1);
        check_eq("stream_count", delivered, n);
        if (check_gaps)
            check_eq("stream_no_gaps", last_cyc - first_cyc, n - 1);
    endtask

    initial begin
        rst_n  = 1'b0;
        d0_dat = '0; d0_val = 1'b0; d0_rdy = 1'b1;
        d1_dat = '0; d1_val = 1'b0;
        d2_dat = '0; d2_val = 1'b0;
        d3_dat = '0; d3_val = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_d0_oval", longint'(d0_oval), 0);
        check_eq("rst_d0_irdy", longint'(d0_irdy), 1);
        check_eq("rst_d1_oval", longint'(d1_oval), 0);

        // d0: all 0xFF, latency 2, single-cycle out_val
        d0_dat = {8{8'hFF}}; d0_val = 1'b1;
        tick();
        d0_val = 1'b0;
        check_eq("d0_lat_edge0", longint'(d0_oval), 0);
        tick();
        check_eq("d0_lat_oval", longint'(d0_oval), 1);
        check_eq("d0_ff_sum", longint'(d0_out), 2040);
        tick();
        check_eq("d0_oval_once", longint'(d0_oval), 0);

        // d1: signed, padded 5 -> 8, latency 3
        d1_dat = 20'h88888; d1_val = 1'b1;
        tick();
        d1_val = 1'b0;
        check_eq("d1_lat_e0", longint'(d1_oval), 0);
        tick();
        check_eq("d1_lat_e1", longint'(d1_oval), 0);
        tick();
        check_eq("d1_lat_oval", longint'(d1_oval), 1);
        check_eq("d1_neg8x5", longint'(d1_out), 7'h58);
        // Back-to-back signed beats: {7 x5} = 35, {-1,2,-3,4,5} = 7
        d1_dat = 20'h77777; d1_val = 1'b1;
        tick();
        d1_dat = 20'h54D2F;
        tick();
        d1_val = 1'b0;
        tick();
        check_eq("d1_pos7x5", longint'(d1_out), 7'h23);
        tick();
        check_eq("d1_mixed", longint'(d1_out), 7'h07);
        check_eq("d1_mixed_oval", longint'(d1_oval), 1);

        // d2: 3 lanes of 0xFF padded to 4, single stage
        d2_dat = {3{8'hFF}}; d2_val = 1'b1;
        tick();
        d2_val = 1'b0;
        check_eq("d2_lat1_oval", longint'(d2_oval), 1);
        check_eq("d2_sum", longint'(d2_out), 765);
        tick();
        check_eq("d2_oval_once", longint'(d2_oval), 0);

        // d3: two lanes of -128, single level, single stage
        d3_dat = {8'h80, 8'h80}; d3_val = 1'b1;
        tick();
        d3_dat = {8'h7F, 8'h80};
        tick();
        d3_val = 1'b0;
        check_eq("d3_mixed", longint'(d3_out), 9'h1FF);
        check_eq("d3_oval", longint'(d3_oval), 1);

        // d0 streaming, then streaming with a 5-cycle output stall
        run_stream(20, 0, 0, 1'b1);
        run_stream(20, 8, 13, 1'b0);

        // Reset with two beats in flight; the reset-cycle beat is dropped too
        d0_rdy = 1'b0;
        d0_dat = {8{8'h11}}; d0_val = 1'b1;
        tick();
        d0_dat = {8{8'h22}};
        tick();
        check_eq("inflight_oval", longint'(d0_oval), 1);
        check_eq("inflight_stall_irdy", longint'(d0_irdy), 0);
        rst_n  = 1'b0;
        d0_dat = {8{8'h33}};
        tick();
        rst_n  = 1'b1;
        d0_val = 1'b0;
        check_eq("midrst_oval", longint'(d0_oval), 0);
        check_eq("midrst_irdy", longint'(d0_irdy), 1);
        d0_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("midrst_no_ghost", longint'(d0_oval), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "timeout");
    end

endmodule
